// File: rtl/decoder_select_sequencer_if.sv
// decoder_select_sequencer_if: control inputs and decoder-select outputs of the scan sequencer
interface decoder_select_sequencer_if;
    logic       start;
    logic       stop;
    logic       hold;
    logic       mode;
    logic       dir;
    logic       load;
    logic [1:0] load_val;
    logic       x;
    logic       y;
    logic       step;
    logic       wrap;
    logic       busy;
    modport master (output start, stop, hold, mode, dir, load, load_val, input x, y, step, wrap, busy);
    modport slave  (input start, stop, hold, mode, dir, load, load_val, output x, y, step, wrap, busy);
endinterface

// File: rtl/decoder_select_sequencer.sv
// decoder_select_sequencer: steps the 2-to-4 decoder select (x,y) through all lines at a prescaled rate
module decoder_select_sequencer #(
    parameter int PRESCALE = 4,
    parameter int CW       = 8
) (
    input logic                        clk,
    input logic                        rst,
    decoder_select_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [1:0]    r_idx, w_idx_nx;
    logic [1:0]    r_xy, w_xy_nx;
    logic          r_step, r_wrap;
    logic          w_tick, w_wrap_nx;
    function automatic logic [1:0] enc(input logic [1:0] i, input logic g);
        return g ? (i ^ {1'b0, i[1]}) : i;
    endfunction
    always_comb begin
        w_tick     = (r_state != IDLE) && !bus.hold && (r_cnt == LAST);
        w_wrap_nx  = w_tick && (bus.dir ? (r_idx == 2'd0) : (r_idx == 2'd3));
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_xy_nx    = r_xy;
        if (r_state == IDLE) begin
            if (bus.load) begin
                w_idx_nx = bus.load_val;
                w_xy_nx  = enc(bus.load_val, bus.mode);
            end
            if (bus.start) begin
                w_state_nx = RUN;
                w_cnt_nx   = '0;
            end
        end else begin
            if (w_tick) begin
                w_cnt_nx = '0;
                w_idx_nx = bus.dir ? r_idx - 2'd1 : r_idx + 2'd1;
                w_xy_nx  = enc(w_idx_nx, bus.mode);
            end else if (!bus.hold) begin
                w_cnt_nx = r_cnt + 1'b1;
            end
            // a wrapping step ends a stopping sweep even if start arrives with it
            if (r_state == RUN && bus.stop)
                w_state_nx = STOP;
            else if (r_state == STOP && w_wrap_nx)
                w_state_nx = IDLE;
            else if (r_state == STOP && bus.start)
                w_state_nx = RUN;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_xy    <= '0;
            r_step  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_xy    <= w_xy_nx;
            r_step  <= w_tick;
            r_wrap  <= w_wrap_nx;
        end
    end
    assign bus.x    = r_xy[1];
    assign bus.y    = r_xy[0];
    assign bus.step = r_step;
    assign bus.wrap = r_wrap;
    assign bus.busy = (r_state != IDLE);
endmodule

// File: tb/tb_decoder_select_sequencer.sv
// tb_decoder_select_sequencer: table vectors, corner sequences and random stimulus vs a dwell-based model
module tb_decoder_select_sequencer;
    logic clk = 1'b0;
    logic rst, start, stop, hold, mode, dir, load;
    logic [1:0] load_val;
    int n_vec = 0;
    int n_err = 0;
    decoder_select_sequencer_if b4 ();
    decoder_select_sequencer_if b1 ();
    assign b4.start = start;    assign b1.start = start;
    assign b4.stop = stop;      assign b1.stop = stop;
    assign b4.hold = hold;      assign b1.hold = hold;
    assign b4.mode = mode;      assign b1.mode = mode;
    assign b4.dir = dir;        assign b1.dir = dir;
    assign b4.load = load;      assign b1.load = load;
    assign b4.load_val = load_val;
    assign b1.load_val = load_val;
    decoder_select_sequencer #(.PRESCALE(4), .CW(8)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
    decoder_select_sequencer #(.PRESCALE(1), .CW(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    logic [4:0] w_o4, w_o1;
    assign w_o4 = {b4.x, b4.y, b4.step, b4.wrap, b4.busy};
    assign w_o1 = {b1.x, b1.y, b1.step, b1.wrap, b1.busy};
    always #5 clk = ~clk;

    // reference: phase 0 idle / 1 scanning / 2 finishing sweep; dwell counts down remaining cycles
    int gray_of [4] = '{0, 1, 3, 2};
    int m_ph [2];
    int m_idx [2];
    int m_left [2];
    int m_xy [2];
    bit m_step [2];
    bit m_wrap [2];

    function automatic int ps(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic logic [4:0] mexp(input int k);
        logic [1:0] xy;
        xy = 2'(m_xy[k]);
        return {xy, m_step[k], m_wrap[k], m_ph[k] != 0};
    endfunction

    task automatic model_step(input int k);
        int ph;
        if (rst) begin
            m_ph[k] = 0; m_idx[k] = 0; m_left[k] = ps(k); m_xy[k] = 0; m_step[k] = 0; m_wrap[k] = 0;
        end else begin
            m_step[k] = 0;
            m_wrap[k] = 0;
            ph = m_ph[k];
            if (ph == 0) begin
                if (load) begin
                    m_idx[k] = int'(load_val);
                    m_xy[k] = mode ? gray_of[m_idx[k]] : m_idx[k];
                end
                if (start) begin
                    m_ph[k] = 1;
                    m_left[k] = ps(k);
                end
            end else begin
                if (!hold) begin
                    m_left[k] = m_left[k] - 1;
                    if (m_left[k] == 0) begin
                        m_left[k] = ps(k);
                        m_wrap[k] = dir ? (m_idx[k] == 0) : (m_idx[k] == 3);
                        m_idx[k] = (m_idx[k] + (dir ? 3 : 1)) % 4;
                        m_xy[k] = mode ? gray_of[m_idx[k]] : m_idx[k];
                        m_step[k] = 1;
                    end
                end
                if (ph == 1 && stop) m_ph[k] = 2;
                else if (ph == 2 && m_wrap[k]) m_ph[k] = 0;
                else if (ph == 2 && start) m_ph[k] = 1;
            end
        end
    endtask

    task automatic check(input string nm, input logic [4:0] act, input logic [4:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b (x y step wrap busy) at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check("model_p4", w_o4, mexp(0));
        check("model_p1", w_o1, mexp(1));
    endtask

    task automatic clr();
        rst = 0; start = 0; stop = 0; hold = 0; load = 0; load_val = 0;
    endtask

    task automatic rst_cycle();
        clr();
        rst = 1;
        cyc();
        rst = 0;
    endtask

    task automatic wait_step(input int lim, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!b4.step && n < lim);
    endtask

    typedef struct {
        logic rst, start, stop, hold, mode, dir, load;
        logic [1:0] lv;
        int n;
        logic [4:0] exp;
    } vec_t;
    vec_t tbl [36];

    function automatic vec_t mk(input logic r, s, p, h, m, d, l, input logic [1:0] lv, input int n, input logic [4:0] e);
        vec_t v;
        v.rst = r; v.start = s; v.stop = p; v.hold = h; v.mode = m; v.dir = d; v.load = l;
        v.lv = lv; v.n = n; v.exp = e;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, cnt;
        clr();
        mode = 0;
        dir = 0;
        //                 rst st sp ho mo di ld lv  n  x y step wrap busy
        tbl[0]  = mk(1, 0, 0, 0, 1, 0, 0, 0, 1, 5'b00000);
        tbl[1]  = mk(0, 1, 0, 0, 1, 0, 0, 0, 1, 5'b00001);
        tbl[2]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 3, 5'b00001);
        tbl[3]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 5'b01101);
        tbl[4]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 3, 5'b01001);
        tbl[5]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 5'b11101);
        tbl[6]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 3, 5'b11001);
        tbl[7]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 5'b10101);
        tbl[8]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 3, 5'b10001);
        tbl[9]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 5'b00111);
        tbl[10] = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 5'b00001);
        tbl[11] = mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 5'b00000);
        tbl[12] = mk(0, 1, 0, 0, 0, 1, 0, 0, 1, 5'b00001);
        tbl[13] = mk(0, 0, 0, 0, 0, 1, 0, 0, 3, 5'b00001);
        tbl[14] = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 5'b11111);
        tbl[15] = mk(0, 0, 0, 0, 0, 1, 0, 0, 4, 5'b10101);
        tbl[16] = mk(0, 0, 0, 0, 0, 1, 0, 0, 4, 5'b01101);
        tbl[17] = mk(0, 0, 0, 0, 0, 1, 0, 0, 4, 5'b00101);
        tbl[18] = mk(0, 0, 0, 0, 0, 1, 0, 0, 4, 5'b11111);
        tbl[19] = mk(1, 0, 0, 0, 1, 0, 0, 0, 1, 5'b00000);
        tbl[20] = mk(0, 0, 0, 0, 1, 0, 1, 2, 1, 5'b11000);
        tbl[21] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 5'b01000);
        tbl[22] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 5'b01001);
        tbl[23] = mk(0, 0, 0, 0, 0, 0, 1, 3, 3, 5'b01001);
        tbl[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b10101);
        tbl[25] = mk(0, 0, 0, 0, 1, 0, 0, 0, 3, 5'b10001);
        tbl[26] = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 5'b10101);
        tbl[27] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000);
        tbl[28] = mk(0, 0, 1, 1, 0, 0, 0, 0, 2, 5'b00000);
        tbl[29] = mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 5'b00001);
        tbl[30] = mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 5'b00001);
        tbl[31] = mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 5'b00001);
        tbl[32] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b01101);
        tbl[33] = mk(0, 0, 0, 0, 0, 0, 0, 0, 11, 5'b11001);
        tbl[34] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00110);
        tbl[35] = mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 5'b00000);
        for (int i = 0; i < 36; i++) begin
            rst = tbl[i].rst; start = tbl[i].start; stop = tbl[i].stop; hold = tbl[i].hold;
            mode = tbl[i].mode; dir = tbl[i].dir; load = tbl[i].load; load_val = tbl[i].lv;
            repeat (tbl[i].n) cyc();
            check($sformatf("row%0d", i), w_o4, tbl[i].exp);
        end

        // hold stretches one dwell by exactly the held cycles
        rst_cycle();
        mode = 1; dir = 0;
        start = 1; cyc(); start = 0;
        wait_step(20, n);
        check_int("first_step_latency", n, 4);
        cyc();
        hold = 1;
        repeat (3) cyc();
        hold = 0;
        wait_step(20, n);
        check_int("held_dwell_len", n + 4, 7);

        // stop finishes the sweep, then a new start resumes
        rst_cycle();
        mode = 1; dir = 0;
        start = 1; cyc(); start = 0;
        wait_step(20, n);
        repeat (2) cyc();
        stop = 1; cyc(); stop = 0;
        n = 0;
        while (b4.busy && n < 40) begin
            cyc();
            n++;
        end
        check_int("stop_end_xy_wrap_busy", int'({b4.x, b4.y, b4.wrap, b4.busy}), 4'b0010);
        repeat (5) cyc();
        check_int("stop_idle_hold", int'({b4.x, b4.y, b4.busy}), 0);
        start = 1; cyc(); start = 0;
        check_int("restart_busy", int'(b4.busy), 1);
        wait_step(20, n);
        check_int("restart_first_xy", int'({b4.x, b4.y}), 1);
        stop = 1; cyc(); stop = 0;
        repeat (1) cyc();
        start = 1; cyc(); start = 0;
        repeat (16) cyc();
        check_int("resume_from_stop_busy", int'(b4.busy), 1);

        // reset in the middle of a scan
        rst_cycle();
        mode = 1; dir = 0;
        start = 1; cyc(); start = 0;
        n = 0;
        while ({b4.x, b4.y} != 2'b11 && n < 40) begin
            cyc();
            n++;
        end
        check_int("reach_xy11", int'({b4.x, b4.y}), 3);
        rst = 1; cyc(); rst = 0;
        check("after_mid_rst", w_o4, 5'b00000);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            cnt += int'(b4.step) + int'(b1.step);
        end
        check_int("no_step_after_rst", cnt, 0);

        // random stimulus against the reference model
        rst_cycle();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 7) == 0);
            stop = ($urandom_range(0, 15) == 0);
            hold = ($urandom_range(0, 5) == 0);
            load = ($urandom_range(0, 4) == 0);
            load_val = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            if ($urandom_range(0, 11) == 0) dir = ~dir;
            cyc();
        end
        clr();
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
